seq_logical_left_shift: RTL and testbench

Multi-cycle logical left shifter, the counterpart of the combinational logical right shifter. It accepts an operand and shift amount through a start/ready handshake and shifts left one bit per clock, filling zeros. It returns the result with a one-cycle valid pulse. It is intended for area-constrained datapaths where a barrel shifter is not justified.

---
 rtl/lls_pkg.sv | 18 +
 rtl/seq_logical_left_shift.sv | 88 ++++++++
 tb/tb_seq_logical_left_shift.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/lls_pkg.sv
// Shared definitions for the multi-cycle logical left shifter: state codes and
// the helper used to size its shift counter.
package lls_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_logical_left_shift.sv
// Multi-cycle logical left shifter: accepts an operand on Start/Ready, shifts
// one bit per clock filling zeros, and flags the registered result with Valid.
module seq_logical_left_shift
    import lls_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned SHIFT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               Start,
    input  logic [WIDTH-1:0]   A,
    input  logic [SHIFT_W-1:0] Shift_value,
    output logic               Ready,
    output logic               Valid,
    output logic [WIDTH-1:0]   Logical_left_shift_Output
);

    localparam int unsigned CNT_W = clog2(WIDTH + 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] shifted;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] n_load;
    logic             accept;
    logic             last_shift;

    // Amounts at or beyond WIDTH clamp to WIDTH, which drains the word to zero.
    always_comb begin
        n_load = CNT_W'(WIDTH);
        if (32'(Shift_value) < WIDTH) begin
            n_load = CNT_W'(Shift_value);
        end
    end

    assign shifted    = work << 1;
    assign accept     = (state == ST_IDLE) && Start;
    assign last_shift = (state == ST_SHIFT) && (cnt <= CNT_W'(1));
    assign Ready      = (state == ST_IDLE);
    assign Valid      = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        state <= (n_load == '0) ? ST_DONE : ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (last_shift) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work <= '0;
            cnt  <= '0;
        end else if (accept) begin
            work <= A;
            cnt  <= n_load;
        end else if (state == ST_SHIFT) begin
            work <= shifted;
            cnt  <= cnt - CNT_W'(1);
        end
    end

    // Result register only moves on the edge that enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Logical_left_shift_Output <= '0;
        end else if (accept && (n_load == '0)) begin
            Logical_left_shift_Output <= A;
        end else if (last_shift) begin
            Logical_left_shift_Output <= shifted;
        end
    end

endmodule

// File: tb/tb_seq_logical_left_shift.sv
// Self-checking bench for seq_logical_left_shift: directed cases plus random
// operations checked against an arithmetic model of the shift and its latency.
module tb_seq_logical_left_shift;

    logic       clk;
    logic       rst_n;
    logic       Start;
    logic [7:0] A;
    logic [3:0] Shift_value;
    logic       Ready;
    logic       Valid;
    logic [7:0] Logical_left_shift_Output;

    int         total;
    int         bad;
    logic [7:0] last_out;

    seq_logical_left_shift #(.WIDTH(8), .SHIFT_W(4)) dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .Start                     (Start),
        .A                         (A),
        .Shift_value               (Shift_value),
        .Ready                     (Ready),
        .Valid                     (Valid),
        .Logical_left_shift_Output (Logical_left_shift_Output)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] model(input logic [7:0] a, input logic [3:0] s);
        int unsigned k;
        logic [31:0] p;
        k = s;
        if (k >= 8) return 8'd0;
        p = 32'(a) * (32'd1 << k);
        return p[7:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one operation and checks every cycle up to the idle cycle after DONE.
    task automatic run_op(input logic [7:0] a, input logic [3:0] s, input bit hold,
                          input logic [7:0] a2, input logic [3:0] s2);
        int n;
        int cyc;
        logic [7:0] exp;
        n   = (s >= 4'd8) ? 8 : int'(s);
        exp = model(a, s);
        cyc = 0;
        while (Ready !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("ready_before", 32'(Ready), 32'd1);
        A = a; Shift_value = s; Start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        A = a2; Shift_value = s2; Start = hold;
        for (int i = 0; i < n; i++) begin
            chk("busy_ready", 32'(Ready), 32'd0);
            chk("busy_valid", 32'(Valid), 32'd0);
            chk("busy_hold", 32'(Logical_left_shift_Output), 32'(last_out));
            @(negedge clk);
        end
        chk("done_valid", 32'(Valid), 32'd1);
        chk("done_ready", 32'(Ready), 32'd0);
        chk("done_out", 32'(Logical_left_shift_Output), 32'(exp));
        last_out = exp;
        @(negedge clk);
        chk("idle_valid", 32'(Valid), 32'd0);
        chk("idle_ready", 32'(Ready), 32'd1);
        chk("idle_out", 32'(Logical_left_shift_Output), 32'(exp));
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] ra2;
        logic [3:0] rs;
        logic [3:0] rs2;
        total = 0;
        bad = 0;
        last_out = 8'd0;
        rst_n = 1'b0; Start = 1'b0; A = 8'd0; Shift_value = 4'd0;
        #2;
        chk("rst_ready", 32'(Ready), 32'd1);
        chk("rst_valid", 32'(Valid), 32'd0);
        chk("rst_out", 32'(Logical_left_shift_Output), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(8'b00110011, 4'd2, 1'b0, 8'hAA, 4'd5);
        run_op(8'b00001111, 4'd4, 1'b0, 8'h00, 4'd0);
        for (int i = 0; i < 10; i++) begin
            chk("hold_idle_out", 32'(Logical_left_shift_Output), 32'(8'b11110000));
            chk("hold_idle_valid", 32'(Valid), 32'd0);
            @(negedge clk);
        end
        run_op(8'b10100101, 4'd0, 1'b0, 8'h3C, 4'd7);
        run_op(8'b00111100, 4'b1010, 1'b0, 8'hFF, 4'd1);
        run_op(8'hFF, 4'd15, 1'b0, 8'h01, 4'd0);

        // Start held high: second request waits for the idle cycle.
        run_op(8'h5B, 4'd3, 1'b1, 8'hFF, 4'd1);
        run_op(8'hFF, 4'd1, 1'b0, 8'h00, 4'd0);

        // Asynchronous reset in the middle of a shift.
        @(negedge clk);
        A = 8'h81; Shift_value = 4'd6; Start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        Start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_ready", 32'(Ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(Ready), 32'd1);
        chk("midrst_valid", 32'(Valid), 32'd0);
        chk("midrst_out", 32'(Logical_left_shift_Output), 32'd0);
        last_out = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("post_rst_valid", 32'(Valid), 32'd0);
            chk("post_rst_out", 32'(Logical_left_shift_Output), 32'd0);
            @(negedge clk);
        end
        run_op(8'h01, 4'd7, 1'b0, 8'hFE, 4'd2);

        for (int i = 0; i < 25; i++) begin
            ra  = 8'($urandom);
            rs  = 4'($urandom);
            ra2 = 8'($urandom);
            rs2 = 4'($urandom);
            run_op(ra, rs, 1'b0, ra2, rs2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
